imem_loader: RTL and testbench

- Boot-time writer for the instruction memory. The fetch stage reads that memory; this block writes it.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words.
- Writes the words to consecutive IMEM word addresses starting at 0.
- Holds the CPU pipeline until the image is complete, then releases it.
- Sits between the host byte link and the IMEM write port, beside the PC/fetch logic.

---
 rtl/loader_pkg.sv | 23 ++
 rtl/imem_loader_if.sv | 32 +++
 rtl/byte_assembler.sv | 53 +++++
 rtl/imem_loader.sv | 156 +++++++++++++++
 tb/tb_imem_loader.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the IMEM boot loader.
//   state_e    : loader FSM states
//   WORD_BYTES : bytes per IMEM word
//   HDR_BYTES  : header length for the default 16-bit word count
//   hdr_bytes(): header length for an arbitrary count width
package loader_pkg;

    typedef enum logic [1:0] {
        HDR   = 2'd0,
        DATA  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned DEF_CNT_W  = 16;
    localparam int unsigned HDR_BYTES  = DEF_CNT_W / 8;

    function automatic int unsigned hdr_bytes(input int unsigned cnt_w);
        return cnt_w / 8;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and IMEM write port of the boot loader.
//   rx_data/rx_valid/rx_ready : host byte link (valid/ready)
//   im_we/im_addr/im_wdata    : IMEM write port
// master: the loader side; slave: host link producer and IMEM.
interface imem_loader_if #(
    parameter int unsigned ADDR_W = 8
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;

    modport master (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output im_we,
        output im_addr,
        output im_wdata
    );

    modport slave (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  im_we,
        input  im_addr,
        input  im_wdata
    );
endinterface

// File: rtl/byte_assembler.sv
// MSB-first byte shift register with a wrapping byte counter.
//   clk, rst  : clock, synchronous active-high reset
//   clear_i   : zero word and counter (wins over shift_i)
//   shift_i   : shift byte_i into the low end
//   byte_i    : incoming byte
//   word_o    : assembled word (registered)
//   full_o_c  : combinational; this shift completes the word
module byte_assembler #(
    parameter int unsigned BYTES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear_i,
    input  logic               shift_i,
    input  logic [7:0]         byte_i,
    output logic [8*BYTES-1:0] word_o,
    output logic               full_o_c
);

    localparam int unsigned W  = 8 * BYTES;
    localparam int unsigned CW = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  word_q, word_d;

    // Next word/count; counter wraps on the last byte so no clear is needed between words
    always_comb begin
        cnt_d    = cnt_q;
        word_d   = word_q;
        full_o_c = shift_i && (cnt_q == CW'(BYTES - 1));
        if (clear_i) begin
            cnt_d  = '0;
            word_d = '0;
        end else if (shift_i) begin
            word_d = W'({word_q, byte_i});
            cnt_d  = full_o_c ? '0 : cnt_q + CW'(1);
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

    assign word_o = word_q;

endmodule

// File: rtl/imem_loader.sv
// Boot-time IMEM writer: receives a word-count header then big-endian
// words over a byte stream, writes them to IMEM from address 0 and holds
// the CPU until the image is complete.
//   clk, rst     : clock, synchronous active-high reset
//   bus          : byte link in, IMEM write port out
//   start        : reload request, honoured only in DONE
//   cpu_hold     : holds PC/pipeline while 1
//   load_done    : image fully loaded
//   err_overflow : sticky, image exceeded IMEM capacity
module imem_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    imem_loader_if.master        bus,
    input  logic                 start,
    output logic                 cpu_hold,
    output logic                 load_done,
    output logic                 err_overflow
);

    localparam int unsigned HDR_B    = hdr_bytes(CNT_W);
    localparam logic [63:0] CAPACITY = 64'(1) << ADDR_W;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  widx_q, widx_d;
    logic [ADDR_W-1:0] im_addr_q, im_addr_d;
    logic              im_we_q, im_we_d;
    logic              rx_ready_q, rx_ready_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              load_done_q, load_done_d;
    logic              err_q, err_d;

    logic              fire;
    logic              reload;
    logic              hdr_full_c, dat_full_c;
    logic [8*HDR_B-1:0] hdr_word;
    logic [31:0]       dat_word;
    logic [CNT_W-1:0]  n_next;
    logic              ovf;
    logic              last_word;

    assign fire   = bus.rx_valid && rx_ready_q;
    assign reload = (state_q == DONE) && start;

    // Header count assembler; it keeps N for the rest of the load
    byte_assembler #(.BYTES(HDR_B)) u_hdr (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (reload),
        .shift_i  (fire && (state_q == HDR)),
        .byte_i   (bus.rx_data),
        .word_o   (hdr_word),
        .full_o_c (hdr_full_c)
    );

    // Data word assembler; its register doubles as the IMEM write data
    byte_assembler #(.BYTES(WORD_BYTES)) u_dat (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (reload),
        .shift_i  (fire && (state_q == DATA)),
        .byte_i   (bus.rx_data),
        .word_o   (dat_word),
        .full_o_c (dat_full_c)
    );

    // Count value including the byte being accepted now, for the N==0 decision
    assign n_next    = CNT_W'({hdr_word, bus.rx_data});
    assign ovf       = 64'(widx_q) >= CAPACITY;
    assign last_word = (widx_q + CNT_W'(1)) == CNT_W'(hdr_word);

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        widx_d    = widx_q;
        im_addr_d = im_addr_q;
        err_d     = err_q;
        im_we_d   = 1'b0;

        case (state_q)
            HDR: begin
                if (hdr_full_c) begin
                    state_d = (n_next == '0) ? DONE : DATA;
                end
            end
            DATA: begin
                if (dat_full_c) begin
                    state_d = WRITE;
                    // Out-of-range words are consumed but never written; address holds
                    if (ovf) begin
                        err_d = 1'b1;
                    end else begin
                        im_we_d   = 1'b1;
                        im_addr_d = ADDR_W'(widx_q);
                    end
                end
            end
            WRITE: begin
                widx_d  = widx_q + CNT_W'(1);
                state_d = last_word ? DONE : DATA;
            end
            DONE: begin
                if (start) begin
                    state_d   = HDR;
                    widx_d    = '0;
                    im_addr_d = '0;
                    err_d     = 1'b0;
                end
            end
            default: begin
                state_d = HDR;
            end
        endcase

        // Registered outputs track the state being entered
        rx_ready_d  = (state_d == HDR) || (state_d == DATA);
        cpu_hold_d  = (state_d != DONE);
        load_done_d = (state_d == DONE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HDR;
            widx_q      <= '0;
            im_addr_q   <= '0;
            im_we_q     <= 1'b0;
            rx_ready_q  <= 1'b1;
            cpu_hold_q  <= 1'b1;
            load_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            widx_q      <= widx_d;
            im_addr_q   <= im_addr_d;
            im_we_q     <= im_we_d;
            rx_ready_q  <= rx_ready_d;
            cpu_hold_q  <= cpu_hold_d;
            load_done_q <= load_done_d;
            err_q       <= err_d;
        end
    end

    assign bus.rx_ready = rx_ready_q;
    assign bus.im_we    = im_we_q;
    assign bus.im_addr  = im_addr_q;
    assign bus.im_wdata = dat_word;
    assign cpu_hold     = cpu_hold_q;
    assign load_done    = load_done_q;
    assign err_overflow = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized bench for imem_loader (ADDR_W=2, CNT_W=16).
module tb_imem_loader;

    localparam int unsigned AW  = 2;
    localparam int          CAP = 4;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic cpu_hold;
    logic load_done;
    logic err_overflow;

    imem_loader_if #(.ADDR_W(AW)) bus ();

    imem_loader #(.ADDR_W(AW), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .start        (start),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          cyc;
        logic        err;
    } wr_t;

    wr_t         obs[$];
    int          exp_cyc[$];
    logic [31:0] img[$];
    int          cyc = 0;
    int          bad_ready = 0;
    int          hold_fall_cyc = -1;
    logic        hold_prev = 1'b1;
    int          last_acc = 0;
    int          checks = 0;
    int          errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Write and hold-release observer, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.im_we === 1'b1) begin
            obs.push_back('{int'(bus.im_addr), bus.im_wdata, cyc, err_overflow});
            if (bus.rx_ready !== 1'b0) bad_ready++;
        end
        if (hold_prev === 1'b1 && cpu_hold === 1'b0) hold_fall_cyc = cyc;
        hold_prev = cpu_hold;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int   g;
        logic rdy;
        logic sent;
        g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        repeat (g) begin
            bus.rx_valid = 1'b0;
            @(negedge clk);
        end
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        sent = 1'b0;
        for (int i = 0; i < 50 && !sent; i++) begin
            rdy = bus.rx_ready;
            @(negedge clk);
            if (rdy === 1'b1) begin
                sent     = 1'b1;
                last_acc = cyc;
            end
        end
        bus.rx_valid = 1'b0;
        if (!sent) begin
            checks++;
            errors++;
            $error("FAIL rx_ready_timeout: byte %0h never accepted", b);
        end
    endtask

    task automatic pulse_start(input string tag);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_hold"},    64'(cpu_hold), 64'(1));
        chk({tag, "_done"},    64'(load_done), 64'(0));
        chk({tag, "_err_clr"}, 64'(err_overflow), 64'(0));
        chk({tag, "_addr0"},   64'(bus.im_addr), 64'(0));
    endtask

    // Reference: word i is written at address i iff i < CAP, at the cycle its
    // fourth byte is accepted; hold drops one cycle after the last write
    // (same cycle as the final header byte for an empty image).
    task automatic run_load(input int n, input int gap, input string tag);
        logic [15:0] nn;
        logic [31:0] w;
        int          exp_wr;
        nn = 16'(n);
        obs.delete();
        exp_cyc.delete();
        bad_ready     = 0;
        hold_fall_cyc = -1;
        send_byte(nn[15:8], gap);
        send_byte(nn[7:0], gap);
        for (int i = 0; i < n; i++) begin
            w = img[i];
            for (int b = 3; b >= 0; b--) send_byte(w[8*b +: 8], gap);
            if (i < CAP) exp_cyc.push_back(last_acc);
        end
        for (int k = 0; k < 10 && load_done !== 1'b1; k++) @(negedge clk);
        #1;
        exp_wr = (n < CAP) ? n : CAP;
        chk({tag, "_wr_count"}, 64'(obs.size()), 64'(exp_wr));
        for (int i = 0; i < exp_wr && i < obs.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), 64'(obs[i].addr), 64'(i));
            chk($sformatf("%s_data%0d", tag, i), 64'(obs[i].data), 64'(img[i]));
            chk($sformatf("%s_cyc%0d",  tag, i), 64'(obs[i].cyc),  64'(exp_cyc[i]));
            chk($sformatf("%s_werr%0d", tag, i), 64'(obs[i].err),  64'(0));
        end
        chk({tag, "_ready_in_write"}, 64'(bad_ready), 64'(0));
        chk({tag, "_load_done"}, 64'(load_done), 64'(1));
        chk({tag, "_cpu_hold"},  64'(cpu_hold), 64'(0));
        chk({tag, "_rx_ready"},  64'(bus.rx_ready), 64'(0));
        chk({tag, "_err"},       64'(err_overflow), 64'(n > CAP));
        chk({tag, "_hold_fall"}, 64'(hold_fall_cyc), 64'(last_acc + ((n == 0) ? 0 : 1)));
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        start        = 1'b0;
        bus.rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        rst          = 1'b1;
        start        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        @(negedge clk);
        do_reset();

        chk("rst_rx_ready", 64'(bus.rx_ready), 64'(1));
        chk("rst_im_we",    64'(bus.im_we), 64'(0));
        chk("rst_im_addr",  64'(bus.im_addr), 64'(0));
        chk("rst_im_wdata", 64'(bus.im_wdata), 64'(0));
        chk("rst_cpu_hold", 64'(cpu_hold), 64'(1));
        chk("rst_load_done", 64'(load_done), 64'(0));
        chk("rst_err",      64'(err_overflow), 64'(0));

        img = '{32'h1234_5678, 32'h9ABC_DEF0};
        run_load(2, 0, "basic");

        pulse_start("st_empty");
        img.delete();
        run_load(0, 0, "empty");

        pulse_start("st_gaps");
        img.delete();
        repeat (3) img.push_back($urandom);
        run_load(3, 3, "gaps");

        pulse_start("st_ovf");
        img.delete();
        repeat (6) img.push_back($urandom);
        run_load(6, 0, "ovf");
        chk("ovf_addr_no_wrap", 64'(bus.im_addr), 64'(CAP - 1));

        pulse_start("st_reload");
        img = '{32'h0000_0001};
        run_load(1, 0, "reload");

        // Reset in the middle of a word: two data bytes in, then rst
        pulse_start("st_rstmid");
        obs.delete();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        do_reset();
        chk("rstmid_no_write", 64'(obs.size()), 64'(0));
        chk("rstmid_hold", 64'(cpu_hold), 64'(1));
        img = '{32'hAABB_CCDD};
        run_load(1, 0, "rstmid");

        // Random images; a stray start pulse in HDR must be ignored
        for (int r = 0; r < 6; r++) begin
            pulse_start($sformatf("st_rand%0d", r));
            if (r[0]) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            n = int'($urandom_range(7, 0));
            img.delete();
            repeat (n) img.push_back($urandom);
            run_load(n, int'($urandom_range(3, 0)), $sformatf("rand%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
